uart_ctrl: RTL and testbench
============================

# uart_ctrl

Memory-mapped controller that sequences the UART transmitter/receiver pair for the single-cycle CPU. It exposes TXD/RXD/CON registers on the CPU data bus and buffers outgoing bytes in a small TX FIFO. It drives the Sender through a TX_EN/TX_STATUS handshake, captures received bytes on RX_STATUS, and raises an interrupt request. It sits between the peripheral address decoder and the Uart block.

## Interface
Parameters:
- TX_DEPTH, 4: TX FIFO entries; power of two, 2..16.
- BASE_ADDR, 32'h4000_0018: address of TXD; RXD is BASE+4, CON is BASE+8.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  CPU data address.
- wdata  in  32  CPU write data.
- MemRead  in  1  bus read strobe.
- MemWrite  in  1  bus write strobe.
- rdata  out  32  read data; combinational from addr; 0 when no register matches.
- tx_data  out  8  byte presented to the Sender.
- tx_en  out  1  send request to the Sender.
- tx_status  in  1  Sender idle (1) / busy (0).
- rx_data  in  8  byte from the Receiver.
- rx_status  in  1  Receiver byte-ready flag.
- irq  out  1  interrupt request, level-sensitive.

## Operation
- **TXD write:** pushes wdata[7:0].
  - If the FIFO is full and not popped in the same cycle, the byte is dropped and sticky TX_OVF is set.
  - TXD reads return 0.
- **TX FSM**, states IDLE, REQ, BUSY, DONE:
  - IDLE→REQ when the FIFO is non-empty and tx_status=1. The FIFO head is registered onto tx_data and popped.
  - REQ holds tx_en=1 until tx_status=0, then goes to BUSY. tx_en is held, not pulsed, because the Sender runs on the slower sample clock.
  - BUSY→DONE when tx_status=1.
  - DONE→REQ if the FIFO is non-empty, otherwise →IDLE and sets TX_DONE.
- **RX path:**
  - rx_status passes through a 2-flop synchronizer. A rising edge of the synchronized signal captures rx_data into rx_buf and sets RX_VALID.
  - If RX_VALID is already 1, the capture still overwrites rx_buf and sets sticky RX_OVR.
- **RXD read:** rdata = {24'b0, rx_buf}; clears RX_VALID at the clock edge.
  - Same-cycle capture wins: RX_VALID stays 1 and RX_OVR is not set.
- **CON register:**
  - [0] TX_IE, RW.
  - [1] RX_IE, RW.
  - [2] RX_VALID, RO.
  - [3] TX_DONE, RO; cleared on CON read.
  - [4] TX_FULL, RO.
  - [5] TX_OVF, RO; cleared on CON read.
  - [6] RX_OVR, RO; cleared on CON read.
  - [31:7] read 0.
  - A CON write affects only [1:0].
  - A set event coinciding with a clearing read leaves the bit set.
- Read side effects apply only when MemRead=1 and the address matches exactly.

## Timing
- Reset values:
  - rdata reflects reset state.
  - tx_en=0, tx_data=0, irq=0.
  - FIFO empty, FSM in IDLE, rx_buf=0, CON=0.
  - Reset mid-transfer drops tx_en immediately; the in-flight Sender frame is not tracked.
- rdata has zero latency (combinational). Register updates take effect at the next posedge clk.
- TXD write to tx_en with an empty FIFO and idle Sender: tx_en rises 1 cycle after the write edge.
- rx_status rise to RX_VALID=1: 3 clk cycles (2 sync stages plus the edge detect).
- The FIFO pointers carry one extra wrap bit: full when the pointers are equal except the MSB, empty when fully equal.

## Configuration
- UART_IRQ_EN defined:
  - irq = (TX_IE & TX_DONE) | (RX_IE & RX_VALID), registered, so it follows the flag by 1 cycle.
- UART_IRQ_EN undefined:
  - irq is tied to 0.
  - CON[1:0] are not implemented: they read 0 and ignore writes.
  - All other behaviour is unchanged.

## Structure
- Package uart_ctrl_pkg holds:
  - register offsets: TXD 0, RXD 4, CON 8;
  - CON bit index constants;
  - the TX FSM state enum.
- Sub-module uart_tx_fifo is a synchronous FIFO parameterised by depth and width 8, with push, pop, full, empty, dout.

## Test plan
- **Single byte:** reset; write TXD=0x55 → tx_data=0x55, tx_en=1 until the model drops tx_status. After tx_status returns to 1, CON reads 0x08, then reads 0x00.
- **Full FIFO:** hold tx_status=0 and write 6 bytes 0x01–0x06 (TX_DEPTH=4). The FSM pops 0x01 into REQ, so 0x02–0x05 fill the FIFO and 0x06 is dropped. → CON[4]=1, CON[5]=1. Release tx_status → the wire order is 0x01–0x05.
- **RX capture:** pulse rx_status with rx_data=0xA3 → RX_VALID=1 after 3 cycles. RXD read returns 0x000000A3 and RX_VALID=0 on the next cycle.
- **RX overrun:** two rx_status rises (0x11 then 0x22) with no read → RXD=0x22, CON[6]=1.
- **Interrupt (UART_IRQ_EN):** CON=0x2 plus a received byte → irq=1. RXD read → irq=0 one cycle later. Undefined build → irq stays 0.
- **Reset in REQ:** assert reset while tx_en=1 → tx_en=0 and CON=0 immediately. The FIFO is empty after release.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART controller: register offsets, CON bit positions
// and TX sequencer state encodings.
package uart_ctrl_pkg;

    localparam logic [31:0] OFF_TXD = 32'h0000_0000;
    localparam logic [31:0] OFF_RXD = 32'h0000_0004;
    localparam logic [31:0] OFF_CON = 32'h0000_0008;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_RX_VALID = 2;
    localparam int CON_TX_DONE  = 3;
    localparam int CON_TX_FULL  = 4;
    localparam int CON_TX_OVF   = 5;
    localparam int CON_RX_OVR   = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE = ST_IDLE,
        TX_REQ  = ST_REQ,
        TX_BUSY = ST_BUSY,
        TX_DONE = ST_DONE
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate count.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON registers, TX FIFO, Sender handshake
// and RX capture. Define UART_IRQ_EN to implement CON[1:0] enables and the irq output.
//
// state | meaning
// IDLE  | no byte in flight; waits for FIFO data and an idle Sender
// REQ   | tx_en held high until the Sender reports busy
// BUSY  | Sender shifting the byte out
// DONE  | Sender idle again; chain next byte or flag TX_DONE
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int          TX_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic        irq
);
    tx_state_e  r_state;
    logic [7:0] r_tx_data;
    logic       r_tx_done;
    logic       r_tx_ovf;
    logic [1:0] r_rx_sync;
    logic       r_rx_prev;
    logic [7:0] r_rx_buf;
    logic       r_rx_valid;
    logic       r_rx_ovr;

    logic       w_sel_txd, w_sel_rxd, w_sel_con;
    logic       w_wr_txd, w_rd_rxd, w_rd_con;
    logic       w_full, w_empty, w_pop;
    logic [7:0] w_dout;
    logic       w_rx_cap;
    logic [1:0] w_ie;
    logic       w_unused;

    assign w_sel_txd = (addr == BASE_ADDR + OFF_TXD);
    assign w_sel_rxd = (addr == BASE_ADDR + OFF_RXD);
    assign w_sel_con = (addr == BASE_ADDR + OFF_CON);
    assign w_wr_txd  = MemWrite && w_sel_txd;
    assign w_rd_rxd  = MemRead && w_sel_rxd;
    assign w_rd_con  = MemRead && w_sel_con;
    assign w_unused  = ^wdata[31:8];

    assign w_pop = !w_empty && (((r_state == TX_IDLE) && tx_status) || (r_state == TX_DONE));

    uart_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr_txd),
        .i_pop   (w_pop),
        .i_din   (wdata[7:0]),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dout  (w_dout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= TX_IDLE;
            r_tx_data <= 8'h00;
            r_tx_done <= 1'b0;
            r_tx_ovf  <= 1'b0;
        end else begin
            if (w_pop) r_tx_data <= w_dout;
            case (r_state)
                TX_IDLE: if (w_pop) r_state <= TX_REQ;
                TX_REQ:  if (!tx_status) r_state <= TX_BUSY;
                TX_BUSY: if (tx_status) r_state <= TX_DONE;
                TX_DONE: r_state <= w_pop ? TX_REQ : TX_IDLE;
                default: r_state <= TX_IDLE;
            endcase
            r_tx_done <= ((r_state == TX_DONE) && w_empty) || (r_tx_done && !w_rd_con);
            r_tx_ovf  <= (w_wr_txd && w_full && !w_pop) || (r_tx_ovf && !w_rd_con);
        end
    end

    assign tx_en   = (r_state == TX_REQ);
    assign tx_data = r_tx_data;

    // rx_status comes from the slower sample-clock domain.
    assign w_rx_cap = r_rx_sync[1] && !r_rx_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_sync  <= 2'b00;
            r_rx_prev  <= 1'b0;
            r_rx_buf   <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], rx_status};
            r_rx_prev  <= r_rx_sync[1];
            if (w_rx_cap) r_rx_buf <= rx_data;
            r_rx_valid <= w_rx_cap || (r_rx_valid && !w_rd_rxd);
            r_rx_ovr   <= (w_rx_cap && r_rx_valid && !w_rd_rxd) || (r_rx_ovr && !w_rd_con);
        end
    end

`ifdef UART_IRQ_EN
    logic [1:0] r_ie;
    logic       r_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ie  <= 2'b00;
            r_irq <= 1'b0;
        end else begin
            if (MemWrite && w_sel_con) r_ie <= wdata[1:0];
            r_irq <= (r_ie[CON_TX_IE] && r_tx_done) || (r_ie[CON_RX_IE] && r_rx_valid);
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 2'b00;
    assign irq  = 1'b0;
`endif

    always_comb begin
        rdata = 32'h0;
        if (w_sel_rxd) begin
            rdata = {24'h0, r_rx_buf};
        end else if (w_sel_con) begin
            rdata[CON_RX_IE:CON_TX_IE] = w_ie;
            rdata[CON_RX_VALID]        = r_rx_valid;
            rdata[CON_TX_DONE]         = r_tx_done;
            rdata[CON_TX_FULL]         = w_full;
            rdata[CON_TX_OVF]          = r_tx_ovf;
            rdata[CON_RX_OVR]          = r_rx_ovr;
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: TX bytes go through a scoreboard queue checked
// against what the Sender handshake sees; register reads are checked inline.
module tb_uart_ctrl;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
`ifdef UART_IRQ_EN
    localparam logic        IRQ_ON = 1'b1;
`else
    localparam logic        IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] IE_RX = IRQ_ON ? 32'h2 : 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        MemRead, MemWrite;
    logic [7:0]  tx_data, rx_data;
    logic        tx_en, tx_status, rx_status, irq;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb[$];
    logic [31:0] rd;

    uart_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr    = a;
        MemRead = 1'b0;
        #1 d = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; MemRead = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        MemRead = 1'b0; addr = '0;
    endtask

    task automatic serve_one(input string tag);
        logic [7:0] e;
        int n;
        e = 8'hxx;
        n = 0;
        while (tx_en !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check({tag, " tx_en"}, 32'(tx_en), 32'h1);
        if (sb.size() > 0) e = sb.pop_front();
        check({tag, " tx_data"}, 32'(tx_data), 32'(e));
        repeat (2) @(negedge clk);
        check({tag, " tx_en held"}, 32'(tx_en), 32'h1);
        tx_status = 1'b0;
        n = 0;
        while (tx_en !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        check({tag, " tx_en drop"}, 32'(tx_en), 32'h0);
        repeat (3) @(negedge clk);
        tx_status = 1'b1;
        @(negedge clk);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_status = 1'b1;
        repeat (4) @(negedge clk);
        rx_status = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; addr = '0; wdata = '0; MemRead = 1'b0; MemWrite = 1'b0;
        tx_status = 1'b1; rx_data = 8'h00; rx_status = 1'b0;
        repeat (2) @(negedge clk);
        check("reset tx_en", 32'(tx_en), 32'h0);
        check("reset tx_data", 32'(tx_data), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        peek(A_CON, rd); check("reset CON", rd, 32'h0);
        peek(A_RXD, rd); check("reset RXD", rd, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        bus_read(A_TXD, rd); check("TXD reads 0", rd, 32'h0);
        peek(A_TXD + 32'hC, rd); check("unmapped 0", rd, 32'h0);

        // single byte
        bus_write(A_TXD, 32'h55); sb.push_back(8'h55);
        check("tx_en before", 32'(tx_en), 32'h0);
        @(negedge clk);
        check("tx_en latency", 32'(tx_en), 32'h1);
        serve_one("single");
        repeat (2) @(negedge clk);
        bus_read(A_CON, rd); check("CON tx_done", rd, 32'h08);
        bus_read(A_CON, rd); check("CON cleared", rd, 32'h00);

        // full FIFO with drop
        bus_write(A_TXD, 32'h01);
        sb.push_back(8'h01);
        @(negedge clk);
        check("ff tx_en", 32'(tx_en), 32'h1);
        check("ff tx_data", 32'(tx_data), 32'(sb.pop_front()));
        tx_status = 1'b0;
        @(negedge clk);
        for (int i = 2; i <= 6; i++) begin
            bus_write(A_TXD, 32'(i));
            if (i <= 5) sb.push_back(8'(i));
        end
        bus_read(A_CON, rd); check("CON full+ovf", rd, 32'h30);
        bus_read(A_CON, rd); check("CON full only", rd, 32'h10);
        tx_status = 1'b1;
        for (int i = 0; i < 4; i++) serve_one("fifo order");
        check("sb drained", 32'(sb.size()), 32'h0);
        repeat (2) @(negedge clk);
        bus_read(A_CON, rd); check("CON done after burst", rd, 32'h08);

        // RX capture and interrupt
        bus_write(A_CON, 32'h2);
        peek(A_CON, rd); check("CON ie", rd, IE_RX);
        rx_data = 8'hA3; rx_status = 1'b1;
        @(negedge clk); peek(A_CON, rd); check("rx sync 1", rd, IE_RX);
        @(negedge clk); peek(A_CON, rd); check("rx sync 2", rd, IE_RX);
        @(negedge clk); peek(A_CON, rd); check("rx valid", rd, IE_RX | 32'h04);
        check("irq lag", 32'(irq), 32'h0);
        @(negedge clk); check("irq set", 32'(irq), 32'(IRQ_ON));
        rx_status = 1'b0;
        bus_read(A_RXD, rd); check("RXD A3", rd, 32'hA3);
        check("irq still", 32'(irq), 32'(IRQ_ON));
        peek(A_CON, rd); check("rx valid cleared", rd, IE_RX);
        @(negedge clk); check("irq cleared", 32'(irq), 32'h0);
        bus_write(A_CON, 32'h0);

        // RX overrun
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_read(A_CON, rd); check("CON overrun", rd, 32'h44);
        bus_read(A_RXD, rd); check("RXD 22", rd, 32'h22);
        peek(A_CON, rd); check("CON after ovr", rd, 32'h00);

        // reset while in REQ with a byte still queued
        bus_write(A_TXD, 32'h77);
        bus_write(A_TXD, 32'h78);
        check("req before reset", 32'(tx_en), 32'h1);
        reset = 1'b0;
        #1;
        check("reset drops tx_en", 32'(tx_en), 32'h0);
        check("reset tx_data", 32'(tx_data), 32'h0);
        peek(A_CON, rd); check("reset CON mid", rd, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("fifo empty after reset", 32'(tx_en), 32'h0);
        peek(A_CON, rd); check("CON after reset", rd, 32'h0);
        check("irq after reset", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
